// File: rtl/conv_pkg.sv
// Shared constants and types for the 3x3 streaming correlation engine.
package conv_pkg;

  localparam int DATA_W = 8;
  localparam int OUT_W  = 21;
  localparam int KSIZE  = 3;

  // One image column (top row at index 0), two's complement pixels.
  typedef logic signed [KSIZE-1:0][DATA_W-1:0] pix_col_t;

endpackage

// File: rtl/shift_col3.sv
// KSIZE x KSIZE column shift register: new column enters at the newest
// position, the oldest column (index 0) falls out. Holds when disabled.
module shift_col3 import conv_pkg::KSIZE; #(
  parameter int W = conv_pkg::DATA_W
) (
  input  logic                                  clk,
  input  logic                                  i_rst,
  input  logic                                  i_en,
  input  logic [KSIZE-1:0][W-1:0]               i_col,
  output logic [KSIZE-1:0][KSIZE-1:0][W-1:0]    o_win
);

  // indexed [row][col], col 0 = oldest
  logic [KSIZE-1:0][KSIZE-1:0][W-1:0] win_q;
  logic [KSIZE-1:0][KSIZE-1:0][W-1:0] win_d;

  // Next-state: shift every row one column towards the oldest slot.
  always_comb begin
    win_d = win_q;
    if (i_en) begin
      for (int unsigned r = 0; r < KSIZE; r++) begin
        for (int unsigned c = 0; c < KSIZE - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KSIZE-1] = i_col[r];
      end
    end
  end

  // Window storage, cleared asynchronously.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) win_q <= '0;
    else       win_q <= win_d;
  end

  assign o_win = win_q;

endmodule

// File: rtl/conv_2d_3x3.sv
// Streaming 3x3 correlation: kernel and pixel windows are column shift
// registers; a 9-term exact signed MAC feeds one registered output.
module conv_2d_3x3 import conv_pkg::KSIZE; #(
  parameter int DATA_W = conv_pkg::DATA_W,
  parameter int OUT_W  = conv_pkg::OUT_W
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_load_knl,
  input  logic              i_en_conv,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [DATA_W-1:0] i_data3,
  output logic [OUT_W-1:0]  o_pixel
);

  logic [KSIZE-1:0][DATA_W-1:0]             col_in;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0]  knl;
  logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0]  win;
  logic                                     win_en;
  logic signed [2*DATA_W-1:0]               prod [KSIZE][KSIZE];
  logic signed [OUT_W-1:0]                  pixel_d;
  logic        [OUT_W-1:0]                  pixel_q;

  assign col_in[0] = i_data1;
  assign col_in[1] = i_data2;
  assign col_in[2] = i_data3;

  // Kernel load takes priority; the window only moves when not loading.
  assign win_en = i_en_conv & ~i_load_knl;

  shift_col3 #(.W(DATA_W)) u_knl (
    .clk   (clk),
    .i_rst (i_rst),
    .i_en  (i_load_knl),
    .i_col (col_in),
    .o_win (knl)
  );

  shift_col3 #(.W(DATA_W)) u_win (
    .clk   (clk),
    .i_rst (i_rst),
    .i_en  (win_en),
    .i_col (col_in),
    .o_win (win)
  );

  // Exact products, sign-extended and summed (no rounding or clamping).
  always_comb begin
    pixel_d = '0;
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE; c++) begin
        prod[r][c] = $signed(win[r][c]) * $signed(knl[r][c]);
        pixel_d    = pixel_d + OUT_W'(prod[r][c]);
      end
    end
  end

  // Output register reloads every cycle from the current window.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) pixel_q <= '0;
    else       pixel_q <= pixel_d;
  end

  assign o_pixel = pixel_q;

endmodule

// File: tb/tb_conv_2d_3x3.sv
// Scoreboard bench for conv_2d_3x3: a behavioural kernel/window model
// pushes the expected output each cycle; the DUT output one cycle later
// is popped and compared.
module tb_conv_2d_3x3;

  localparam int DW = 8;
  localparam int OW = 21;

  logic          clk;
  logic          i_rst;
  logic          i_load_knl;
  logic          i_en_conv;
  logic [DW-1:0] i_data1;
  logic [DW-1:0] i_data2;
  logic [DW-1:0] i_data3;
  logic [OW-1:0] o_pixel;

  int checks;
  int failures;

  int mk [3][3];
  int mw [3][3];
  int exp_q [$];
  int frame [3][12];

  conv_2d_3x3 #(.DATA_W(DW), .OUT_W(OW)) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_load_knl (i_load_knl),
    .i_en_conv  (i_en_conv),
    .i_data1    (i_data1),
    .i_data2    (i_data2),
    .i_data3    (i_data3),
    .o_pixel    (o_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model_conv();
    int s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += mw[r][c] * mk[r][c];
    return s;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        mk[r][c] = 0;
        mw[r][c] = 0;
      end
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // One clock: drive, take the edge, compare the previous expectation,
  // then advance the model and queue the next expectation.
  task automatic step(input logic ld, input logic en,
                      input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
    int col [3];
    i_load_knl = ld;
    i_en_conv  = en;
    i_data1    = d1;
    i_data2    = d2;
    i_data3    = d3;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_underflow", 1, 0);
    end else begin
      check_eq("sb_pixel", int'($signed(o_pixel)), exp_q.pop_front());
    end
    col[0] = sx8(d1);
    col[1] = sx8(d2);
    col[2] = sx8(d3);
    for (int r = 0; r < 3; r++) begin
      if (ld) begin
        mk[r][0] = mk[r][1]; mk[r][1] = mk[r][2]; mk[r][2] = col[r];
      end else if (en) begin
        mw[r][0] = mw[r][1]; mw[r][1] = mw[r][2]; mw[r][2] = col[r];
      end
    end
    exp_q.push_back(model_conv());
  endtask

  // k given row-major k1..k9; loaded as columns (k1,k4,k7),(k2,k5,k8),(k3,k6,k9).
  task automatic load_kernel(input int k [9]);
    for (int c = 0; c < 3; c++)
      step(1'b1, 1'b0, 8'(k[c]), 8'(k[c+3]), 8'(k[c+6]));
  endtask

  task automatic fill_kernel(input int v);
    int k [9];
    foreach (k[i]) k[i] = v;
    load_kernel(k);
  endtask

  task automatic stream_const(input int v, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 8'(v), 8'(v), 8'(v));
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  initial begin
    int k [9];
    int a [3];
    int b [3];
    int cc [3];
    checks = 0;
    failures = 0;
    model_clear();

    // Reset held with random inputs
    i_rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_load_knl = 1'($urandom);
      i_en_conv  = 1'($urandom);
      i_data1 = 8'($urandom); i_data2 = 8'($urandom); i_data3 = 8'($urandom);
      @(posedge clk);
      #1;
      check_eq("reset_hold", int'($signed(o_pixel)), 0);
    end
    @(negedge clk);
    i_rst = 1'b0;
    exp_q.push_back(model_conv());

    // Unloaded kernel: output stays zero
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    check_eq("unloaded_zero", int'($signed(o_pixel)), 0);

    // Identity kernel over a 3x12 padded frame
    foreach (k[i]) k[i] = 0;
    k[4] = 1;
    load_kernel(k);
    for (int j = 0; j < 12; j++)
      for (int r = 0; r < 3; r++)
        frame[r][j] = (j == 0 || j == 11) ? 0 : $urandom_range(0, 255) - 128;
    for (int j = 0; j <= 12; j++) begin
      if (j < 12) step(1'b0, 1'b1, 8'(frame[0][j]), 8'(frame[1][j]), 8'(frame[2][j]));
      else        idle();
      if (j >= 3) check_eq("identity", int'($signed(o_pixel)), frame[1][j-2]);
    end

    // All-ones kernel with saturated-positive and most-negative pixels
    fill_kernel(1);
    stream_const(127, 3);
    idle();
    check_eq("ones_127", int'($signed(o_pixel)), 1143);
    stream_const(-128, 3);
    idle();
    check_eq("ones_m128", int'($signed(o_pixel)), -1152);

    // Extremes
    fill_kernel(-128);
    stream_const(-128, 3);
    idle();
    check_eq("ext_pos", int'($signed(o_pixel)), 147456);
    fill_kernel(127);
    idle();
    check_eq("ext_neg", int'($signed(o_pixel)), -146304);

    // Orientation: oldest column top-left, newest column bottom-right
    for (int r = 0; r < 3; r++) begin
      a[r]  = $urandom_range(0, 255) - 128;
      b[r]  = $urandom_range(0, 255) - 128;
      cc[r] = $urandom_range(0, 255) - 128;
    end
    foreach (k[i]) k[i] = 0;
    k[0] = 1;
    load_kernel(k);
    step(1'b0, 1'b1, 8'(a[0]), 8'(a[1]), 8'(a[2]));
    step(1'b0, 1'b1, 8'(b[0]), 8'(b[1]), 8'(b[2]));
    step(1'b0, 1'b1, 8'(cc[0]), 8'(cc[1]), 8'(cc[2]));
    idle();
    check_eq("orient_k1", int'($signed(o_pixel)), a[0]);
    k[0] = 0;
    k[8] = 1;
    load_kernel(k);
    idle();
    check_eq("orient_k9", int'($signed(o_pixel)), cc[2]);

    // Random kernel and stream with enable gaps
    foreach (k[i]) k[i] = $urandom_range(0, 255) - 128;
    load_kernel(k);
    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 8'($urandom));

    // Load and enable together: kernel shifts, window holds
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 6; i++)
      step(1'b0, 1'b1, 8'($urandom), 8'($urandom), 8'($urandom));

    // Asynchronous reset mid-stream, visible before any clock edge
    fill_kernel(-128);
    stream_const(-128, 3);
    idle();
    #2;
    i_rst = 1'b1;
    #1;
    check_eq("async_rst", int'($signed(o_pixel)), 0);
    @(negedge clk);
    i_rst = 1'b0;
    model_clear();
    exp_q.delete();
    exp_q.push_back(model_conv());
    stream_const(-128, 4);
    check_eq("post_rst_zero", int'($signed(o_pixel)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_2d_3x3.md
# conv_2d_3x3

Streaming 3x3 two-dimensional convolution (correlation) engine for 8-bit signed image data. A 3x3 signed kernel is loaded one column per cycle. Padded image pixels are then streamed one 3-pixel column per cycle, and the block emits one 21-bit signed filtered pixel per cycle. It sits between the frame preprocessor (zero padding, row-triplet extraction) and the output formatter of the image-processing datapath.

## Interface
- DATA_W, 8: width of kernel coefficients and pixels, two's complement.
- OUT_W, 21: width of o_pixel. Must be at least 2*DATA_W+4.
- clk  in  1  single clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_load_knl  in  1  kernel load strobe; shifts one kernel column per cycle.
- i_en_conv  in  1  convolution enable; shifts one pixel column per cycle.
- i_data1  in  DATA_W  top row: kernel row 1 coefficient, or pixel row r.
- i_data2  in  DATA_W  middle row: kernel row 2 coefficient, or pixel row r+1.
- i_data3  in  DATA_W  bottom row: kernel row 3 coefficient, or pixel row r+2.
- o_pixel  out  OUT_W  signed correlation result, registered.

## Operation
- State:
  - kernel array K[row 1..3][col 1..3], signed DATA_W.
  - window array P[row 1..3][col 1..3], signed DATA_W.
  - output register.
- Kernel load:
  - When i_load_knl=1, the column {i_data1,i_data2,i_data3} shifts into kernel column 3, column 3 moves to column 2, and column 2 moves to column 1.
  - After three load cycles with columns (k1,k4,k7), (k2,k5,k8), (k3,k6,k9), the array holds K = [k1 k2 k3; k4 k5 k6; k7 k8 k9].
  - The kernel holds its value at all other times.
- Pixel shift:
  - When i_en_conv=1 and i_load_knl=0, the input column shifts into window column 3, with the same shift order as the kernel. Column 1 is the oldest.
  - i_load_knl has priority. While loading, the window holds.
  - When i_en_conv=0, the window holds.
- Output:
  - Every cycle, the output register loads sum over r,c of P[r][c]*K[r][c] computed from the current window.
  - The kernel is not flipped; this is correlation.
- Arithmetic:
  - Each product is an exact signed 2*DATA_W-bit value.
  - The 9-term sum is exact. Sign-extend to OUT_W; no rounding, no saturation.
  - Worst case is 9*(-128*-128) = 147456, which fits in 21 bits signed.
- Row boundaries:
  - The window is not flushed between rows.
  - For a padded row of width W+2, outputs after the 3rd through (W+2)th column of that row are valid, giving W results.
  - The first two outputs after a row change mix two rows. The consumer discards them.
- Reset:
  - i_rst=1 asynchronously clears K, P and o_pixel to 0.
  - Reset mid-stream discards the kernel; it must be reloaded.
- A kernel reload mid-stream is legal. The window is preserved, and outputs use the partially updated kernel during the load cycles.

## Timing
- o_pixel reset value: 0.
- Latency: a column sampled at edge N enters the window at edge N. o_pixel reflects that window after edge N+1. This is 1 cycle from capture to output, or 2 edges from input presentation.
- Throughput: one result per clock while i_en_conv=1. No stalls and no backpressure.
- Kernel is usable on the cycle after the third load edge. Asserting i_en_conv in the cycle right after the load is legal.
- Simultaneous i_load_knl and i_en_conv: load wins, window holds.

## Structure
- Shared package, conv_pkg: DATA_W=8, OUT_W=21, KSIZE=3, and a signed pixel-column type (3 x DATA_W).
- Sub-module shift_col3: a 3x3 column shift register with enable, instantiated twice (kernel and window).
- Multiply/add tree inline in conv_2d_3x3: 9 multipliers plus an adder tree into one output register.

## Test plan
- Reset: i_rst=1 with random inputs -> o_pixel=0 and stays 0. Release, then stream with an unloaded kernel -> o_pixel=0.
- Identity kernel (k5=1, others 0), 3x12 padded frame, columns streamed -> after each valid column j (j=2..11), o_pixel equals middle-row pixel of column j-1 on the following cycle. 10 valid outputs.
- All-ones kernel, all pixels 127 -> o_pixel=1143. All pixels -128 -> o_pixel=-1152.
- Extremes: kernel all -128, pixels all -128 -> o_pixel=147456, no overflow. Kernel all 127, pixels all -128 -> o_pixel=-146304.
- Orientation: kernel k1=1 only, window columns A,B,C -> o_pixel equals top-row pixel of A (oldest column). With k9=1 only -> bottom-row pixel of C.
- Control: i_en_conv=0 mid-stream -> o_pixel holds constant. i_load_knl and i_en_conv both 1 -> window unchanged, kernel shifts. Async reset mid-stream -> o_pixel=0 immediately, without waiting for a clock edge.
